// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the FPU normalisation slice: FSM state encoding and
// the shift-count width helper.
package fpu_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } norm_state_e;

    function automatic int cw_of(input int sw);
        return $clog2(sw + 1);
    endfunction

    localparam int SW_DEFAULT = 26;
    localparam int CW_DEFAULT = cw_of(SW_DEFAULT);

endpackage

// File: rtl/lzc_normalizer_if.sv
// Operand/result bundle between the add/subtract stage (master) and the
// leading-zero normaliser (slave).
interface lzc_normalizer_if #(parameter int SW = 26);
    import fpu_norm_pkg::*;
    localparam int CW = cw_of(SW);

    logic          Start_i;
    logic [SW-1:0] Data_Result_i;
    logic          FSM_C_i;
    logic          Add_Sub_i;
    logic [SW-1:0] Norm_Data_o;
    logic [CW-1:0] Shift_Count_o;
    logic          Right_Shift_o;
    logic          Zero_Flag_o;
    logic          Busy_o;
    logic          Ready_o;

    modport master (
        output Start_i, Data_Result_i, FSM_C_i, Add_Sub_i,
        input  Norm_Data_o, Shift_Count_o, Right_Shift_o, Zero_Flag_o, Busy_o, Ready_o
    );

    modport slave (
        input  Start_i, Data_Result_i, FSM_C_i, Add_Sub_i,
        output Norm_Data_o, Shift_Count_o, Right_Shift_o, Zero_Flag_o, Busy_o, Ready_o
    );

endinterface

// File: rtl/lzc_priority_encoder.sv
// Combinational leading-zero counter: returns SW for an all-zero operand,
// otherwise SW-1 minus the index of the most significant set bit.
module lzc_priority_encoder
    import fpu_norm_pkg::*;
#(
    parameter  int SW = 26,
    localparam int CW = cw_of(SW)
) (
    input  logic [SW-1:0] data,
    output logic [CW-1:0] count
);

    // Later (higher) set bits overwrite earlier ones, so the MSB wins.
    always_comb begin
        count = CW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (data[i]) count = CW'(SW - 1 - i);
        end
    end

endmodule

// File: rtl/lzc_normalizer.sv
// Multi-cycle mantissa normaliser: count leading zeros, then shift left by a
// binary-weighted stage per cycle. Optional carry right-shift: NORM_CARRY_EN.
module lzc_normalizer
    import fpu_norm_pkg::*;
#(
    parameter int SW = 26
) (
    input logic              clk,
    input logic              rst,
    lzc_normalizer_if.slave  bus
);

    localparam int CW = cw_of(SW);

    norm_state_e   state_q, state_d;
    logic [SW-1:0] data_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] stage_q;
    logic          zero_q;
    logic          rs_q;
    logic [CW-1:0] lzc_cnt;
    logic [CW-1:0] step;
    logic          carry_take;

`ifdef NORM_CARRY_EN
    assign carry_take = bus.FSM_C_i & ~bus.Add_Sub_i;
`else
    logic unused_carry;
    assign unused_carry = bus.FSM_C_i ^ bus.Add_Sub_i;
    assign carry_take   = 1'b0;
`endif

    lzc_priority_encoder #(.SW(SW)) u_lzc (
        .data  (data_q),
        .count (lzc_cnt)
    );

    assign step = CW'(1) << stage_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start_i) state_d = carry_take ? DONE : COUNT;
            COUNT:   state_d = (lzc_cnt == CW'(SW)) ? DONE : SHIFT;
            SHIFT:   if (stage_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            zero_q  <= 1'b0;
            rs_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Start_i) begin
                        zero_q <= 1'b0;
                        rs_q   <= carry_take;
                        if (carry_take) begin
                            data_q <= {1'b1, bus.Data_Result_i[SW-1:1]};
                            cnt_q  <= '0;
                        end else begin
                            data_q <= bus.Data_Result_i;
                        end
                    end
                end
                COUNT: begin
                    // An all-zero operand is already its own normalised form.
                    cnt_q   <= lzc_cnt;
                    stage_q <= CW'(CW - 1);
                    zero_q  <= (lzc_cnt == CW'(SW));
                end
                SHIFT: begin
                    if (cnt_q[stage_q]) data_q <= data_q << step;
                    stage_q <= stage_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.Norm_Data_o   = data_q;
    assign bus.Shift_Count_o = cnt_q;
    assign bus.Zero_Flag_o   = zero_q;
    assign bus.Right_Shift_o = rs_q;
    assign bus.Busy_o        = (state_q != IDLE);
    assign bus.Ready_o       = (state_q == DONE);

endmodule

// File: tb/tb_lzc_normalizer.sv
// Self-checking bench for lzc_normalizer: directed corner operands, held-start
// and mid-operation reset scenarios, plus random operands against a reference model.
module tb_lzc_normalizer;
    import fpu_norm_pkg::*;

    localparam int SW = 26;
    localparam int CW = cw_of(SW);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    lzc_normalizer_if #(.SW(SW)) bus ();

    lzc_normalizer #(.SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: normalise by repeated doubling of the integer value.
    task automatic model(input logic [SW-1:0] d, input logic c, input logic as_,
                         output logic [SW-1:0] norm, output logic [CW-1:0] cnt,
                         output logic zf, output logic rs, output int lat);
        longint val;
        int     n;
        val = longint'(d);
        zf  = 1'b0;
        rs  = 1'b0;
`ifdef NORM_CARRY_EN
        if (c && !as_) begin
            norm = SW'((longint'(1) << (SW - 1)) + val / 2);
            cnt  = '0;
            rs   = 1'b1;
            lat  = 1;
            return;
        end
`endif
        if (val == 0) begin
            norm = '0;
            cnt  = CW'(SW);
            zf   = 1'b1;
            lat  = 2;
        end else begin
            n = 0;
            while (val < (longint'(1) << (SW - 1))) begin
                val = val * 2;
                n++;
            end
            norm = SW'(val);
            cnt  = CW'(n);
            lat  = CW + 2;
        end
    endtask

    task automatic run_op(input logic [SW-1:0] d, input logic c, input logic as_,
                          input bit hold_start, input string tag);
        logic [SW-1:0] en;
        logic [CW-1:0] ec;
        logic          ez, er;
        int            el, n;
        model(d, c, as_, en, ec, ez, er, el);
        bus.Start_i       = 1'b1;
        bus.Data_Result_i = d;
        bus.FSM_C_i       = c;
        bus.Add_Sub_i     = as_;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (hold_start) bus.Data_Result_i = SW'($urandom);
            else            bus.Start_i = 1'b0;
            if (n == 1) begin
                chk({tag, "_busy_e0"}, 64'(bus.Busy_o), 64'd1);
                chk({tag, "_zero_clr_e0"}, 64'(bus.Zero_Flag_o), 64'd0);
                chk({tag, "_rs_e0"}, 64'(bus.Right_Shift_o), 64'(er));
            end
        end while (!bus.Ready_o && n < 20);
        bus.Start_i = 1'b0;
        chk({tag, "_ready_seen"}, 64'(bus.Ready_o), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(el));
        chk({tag, "_norm"}, 64'(bus.Norm_Data_o), 64'(en));
        chk({tag, "_count"}, 64'(bus.Shift_Count_o), 64'(ec));
        chk({tag, "_zero"}, 64'(bus.Zero_Flag_o), 64'(ez));
        chk({tag, "_rshift"}, 64'(bus.Right_Shift_o), 64'(er));
        @(posedge clk); #1;
        chk({tag, "_ready_pulse"}, 64'(bus.Ready_o), 64'd0);
        chk({tag, "_idle"}, 64'(bus.Busy_o), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_hold_norm"}, 64'(bus.Norm_Data_o), 64'(en));
        chk({tag, "_hold_count"}, 64'(bus.Shift_Count_o), 64'(ec));
    endtask

    initial begin
        logic [SW-1:0] d;
        int            sh;

        bus.Start_i       = 1'b0;
        bus.Data_Result_i = '0;
        bus.FSM_C_i       = 1'b0;
        bus.Add_Sub_i     = 1'b0;

        #12;
        chk("rst_norm", 64'(bus.Norm_Data_o), 64'd0);
        chk("rst_count", 64'(bus.Shift_Count_o), 64'd0);
        chk("rst_zero", 64'(bus.Zero_Flag_o), 64'd0);
        chk("rst_rshift", 64'(bus.Right_Shift_o), 64'd0);
        chk("rst_busy", 64'(bus.Busy_o), 64'd0);
        chk("rst_ready", 64'(bus.Ready_o), 64'd0);
        #5 rst = 1'b1;
        @(posedge clk); #1;

        run_op(SW'(26'h0000001), 1'b0, 1'b0, 1'b0, "lsb");
        run_op(SW'(26'h2000000), 1'b0, 1'b0, 1'b0, "msb");
        run_op(SW'(26'h0000000), 1'b0, 1'b0, 1'b0, "zero");
        run_op(SW'(26'h3000000), 1'b1, 1'b0, 1'b0, "carry");
        run_op(SW'(26'h3FFFFFF), 1'b0, 1'b1, 1'b0, "ones");
        run_op(SW'(26'h0000100), 1'b1, 1'b1, 1'b0, "sub_c");
        run_op(SW'(26'h0012345), 1'b0, 1'b0, 1'b1, "held_start");

        for (int i = 0; i < 20; i++) begin
            sh = $urandom_range(0, SW);
            d  = SW'($urandom) >> sh;
            run_op(d, 1'($urandom), 1'($urandom), 1'b0, "rand");
        end

        // Abort in the middle of the shift sequence.
        bus.Start_i       = 1'b1;
        bus.Data_Result_i = SW'(26'h0ABCDEF);
        bus.FSM_C_i       = 1'b0;
        @(posedge clk); #1;
        bus.Start_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("abort_norm", 64'(bus.Norm_Data_o), 64'd0);
        chk("abort_count", 64'(bus.Shift_Count_o), 64'd0);
        chk("abort_zero", 64'(bus.Zero_Flag_o), 64'd0);
        chk("abort_busy", 64'(bus.Busy_o), 64'd0);
        chk("abort_ready", 64'(bus.Ready_o), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_ready", 64'(bus.Ready_o), 64'd0);
        end
        #2 rst = 1'b1;
        run_op(SW'(26'h0000100), 1'b0, 1'b0, 1'b0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
